key_encoder: RTL

- Upstream stage of the 3-to-8 decoder. Turns 2**ENCODE_WIDTH raw, bouncy, active-low board keys into one debounced, priority-encoded binary code plus a one-cycle valid strobe.
- The decoder input bus connects directly to code_out.
- Each press is reported once. Further presses are locked out until every key is released, which blocks chord and rollover glitches.

---
 rtl/key_encoder_pkg.sv | 17 +
 rtl/key_debounce.sv | 49 ++++
 rtl/key_encoder.sv | 102 ++++++++++
 3 files changed

// File: rtl/key_encoder_pkg.sv
// Shared definitions for the key encoder and the decoder bench that consumes its code.
// Holds the default code width, the key-count derivation and the FSM state encodings.
package key_encoder_pkg;

  localparam int ENCODE_WIDTH_DEF = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } enc_state_e;

  // Key count is always derived from the code width so the two can never disagree.
  function automatic int key_count(input int encode_width);
    return 1 << encode_width;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One-key debouncer: 2-FF synchronizer on the raw active-low key, then a sample
// shift register that only flips the debounced level after a full run of equal samples.
module key_debounce #(
  parameter int STABLE_SAMPLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic key_n,
  output logic deb
);

  logic                      sync1_q;
  logic                      sync2_q;
  logic [STABLE_SAMPLES-1:0] shift_q;
  logic [STABLE_SAMPLES-1:0] shift_d;
  logic                      deb_q;
  logic                      deb_d;

  // Decision is taken on the post-shift value so deb moves on the same tick edge.
  always_comb begin
    shift_d = {shift_q[STABLE_SAMPLES-2:0], ~sync2_q};
    deb_d   = deb_q;
    if (&shift_d) begin
      deb_d = 1'b1;
    end else if (~|shift_d) begin
      deb_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      shift_q <= '0;
      deb_q   <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      if (tick) begin
        shift_q <= shift_d;
        deb_q   <= deb_d;
      end
    end
  end

  assign deb = deb_q;

endmodule

// File: rtl/key_encoder.sv
// Debounced, priority-encoded keypad front end: reports the lowest newly pressed key
// once with a one-cycle strobe, then locks out further presses until all keys are up.
module key_encoder
  import key_encoder_pkg::*;
#(
  parameter  int ENCODE_WIDTH   = ENCODE_WIDTH_DEF,
  parameter  int TICK_DIV       = 50000,
  parameter  int STABLE_SAMPLES = 4,
  localparam int KEY_WIDTH      = key_count(ENCODE_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [KEY_WIDTH-1:0]    key_in,
  output logic [ENCODE_WIDTH-1:0] code_out,
  output logic                    code_valid,
  output logic                    held
);

  localparam int              CNT_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;
  logic                    tick;
  logic [KEY_WIDTH-1:0]    deb;
  logic [KEY_WIDTH-1:0]    deb_q;
  logic [KEY_WIDTH-1:0]    press;
  logic [ENCODE_WIDTH-1:0] win_idx;
  enc_state_e              state_q;
  logic [ENCODE_WIDTH-1:0] code_q;
  logic                    valid_q;
  logic                    held_q;

  assign tick  = (cnt_q == CNT_MAX);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      deb_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb;
    end
  end

  for (genvar g = 0; g < KEY_WIDTH; g++) begin : g_key
    key_debounce #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .key_n(key_in[g]),
      .deb  (deb[g])
    );
  end

  assign press = deb & ~deb_q;

  // Scan from the top so the lowest asserted index is the one left standing.
  always_comb begin
    win_idx = '0;
    for (int i = KEY_WIDTH - 1; i >= 0; i--) begin
      if (press[i]) begin
        win_idx = ENCODE_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      held_q  <= |deb;
      case (state_q)
        IDLE: begin
          if (|press) begin
            code_q  <= win_idx;
            valid_q <= 1'b1;
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          if (deb == '0) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign code_out   = code_q;
  assign code_valid = valid_q;
  assign held       = held_q;

endmodule
